// File: rtl/sccomp_trace_buf_if.sv
`default_nettype none
// ============================================================================
// Module      : sccomp_trace_buf_if
// Description : Capture-tap and host-read bus of the execution-trace buffer.
// Revision    : 1.0 - initial release
// ============================================================================
interface sccomp_trace_buf_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 16
);
    localparam int c_CNT_W = $clog2(DEPTH) + 1;

    logic [PC_W-1:0]         pc_i;
    logic [INSTR_W-1:0]      instr_i;
    logic                    cap_en;
    logic                    mode;
    logic                    clr;
    logic                    bp_en;
    logic [PC_W-1:0]         bp_addr;
    logic                    rd_req;
    logic [PC_W+INSTR_W-1:0] rd_data;
    logic                    rd_valid;
    logic [c_CNT_W-1:0]      count;
    logic                    full;
    logic                    stopped;

    modport master (
        output pc_i, instr_i, cap_en, mode, clr, bp_en, bp_addr, rd_req,
        input  rd_data, rd_valid, count, full, stopped
    );

    modport slave (
        input  pc_i, instr_i, cap_en, mode, clr, bp_en, bp_addr, rd_req,
        output rd_data, rd_valid, count, full, stopped
    );
endinterface
`default_nettype wire

// File: rtl/sccomp_trace_buf.sv
`default_nettype none
// ============================================================================
// Module      : sccomp_trace_buf
// Description : PC/instruction trace buffer with stop-when-full, circular and
//               PC-breakpoint capture; host drains entries oldest-first.
//               Define TRACE_DEDUP_EN to skip repeated consecutive PCs.
// Revision    : 1.0 - initial release
// ============================================================================
module sccomp_trace_buf #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 16
) (
    input  logic               clk,
    input  logic               rstn,
    sccomp_trace_buf_if.slave  bus
);
    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;
    localparam int c_ENT_W = PC_W + INSTR_W;
    localparam logic [c_CNT_W-1:0] c_FULL_CNT = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ARMED   = 2'd1,
        S_STOPPED = 2'd2
    } state_t;

    state_t               state_q,    state_d;
    logic [c_PTR_W-1:0]   wr_ptr_q,   wr_ptr_d;
    logic [c_PTR_W-1:0]   rd_ptr_q,   rd_ptr_d;
    logic [c_CNT_W-1:0]   count_q,    count_d;
    logic [c_ENT_W-1:0]   rd_data_q,  rd_data_d;
    logic                 rd_valid_q, rd_valid_d;
    logic [c_ENT_W-1:0]   mem_q [DEPTH];
    logic                 w_wr_en;
    logic                 w_dup_skip;

`ifdef TRACE_DEDUP_EN
    logic [PC_W-1:0] last_pc_q,  last_pc_d;
    logic            last_vld_q, last_vld_d;

    assign w_dup_skip = last_vld_q && (bus.pc_i == last_pc_q);

    always_comb begin
        last_pc_d  = last_pc_q;
        last_vld_d = last_vld_q;
        if (bus.clr) begin
            last_vld_d = 1'b0;
        end else if (w_wr_en) begin
            last_pc_d  = bus.pc_i;
            last_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_pc_q  <= '0;
            last_vld_q <= 1'b0;
        end else begin
            last_pc_q  <= last_pc_d;
            last_vld_q <= last_vld_d;
        end
    end
`else
    assign w_dup_skip = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        w_wr_en    = 1'b0;
        if (bus.clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            state_d  = S_IDLE;
        end else begin
            case (state_q)
                S_ARMED: begin
                    if (!bus.cap_en) begin
                        state_d = S_IDLE;
                    end else if (w_dup_skip) begin
                        state_d = S_ARMED;
                    end else if (!bus.mode && (count_q == c_FULL_CNT)) begin
                        // Re-armed onto a full buffer in stop mode: nothing fits.
                        state_d = S_STOPPED;
                    end else begin
                        w_wr_en  = 1'b1;
                        wr_ptr_d = wr_ptr_q + c_PTR_ONE;
                        if (count_q == c_FULL_CNT) begin
                            rd_ptr_d = rd_ptr_q + c_PTR_ONE;
                        end else begin
                            count_d = count_q + c_CNT_ONE;
                        end
                        if ((!bus.mode && (count_d == c_FULL_CNT)) ||
                            (bus.bp_en && (bus.pc_i == bus.bp_addr))) begin
                            state_d = S_STOPPED;
                        end
                    end
                end
                default: begin
                    if (bus.rd_req && (count_q != '0)) begin
                        rd_data_d  = mem_q[rd_ptr_q];
                        rd_valid_d = 1'b1;
                        rd_ptr_d   = rd_ptr_q + c_PTR_ONE;
                        count_d    = count_q - c_CNT_ONE;
                    end
                    if ((state_q == S_IDLE) && bus.cap_en) begin
                        state_d = S_ARMED;
                    end else if ((state_q == S_STOPPED) && !bus.cap_en) begin
                        state_d = S_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    // Storage is qualified by count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            mem_q[wr_ptr_q] <= {bus.pc_i, bus.instr_i};
        end
    end

    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.count    = count_q;
    assign bus.full     = (count_q == c_FULL_CNT);
    assign bus.stopped  = (state_q == S_STOPPED);

endmodule
`default_nettype wire

// File: tb/tb_sccomp_trace_buf.sv
`default_nettype none
// ============================================================================
// Module      : tb_sccomp_trace_buf
// Description : Directed and random stimulus for sccomp_trace_buf, checked
//               against a queue-based model of the trace buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sccomp_trace_buf;
    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 16;
    localparam int ENT_W   = PC_W + INSTR_W;
    localparam int M_IDLE = 0, M_ARMED = 1, M_STOPPED = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    sccomp_trace_buf_if #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) bus();

    sccomp_trace_buf #(.PC_W(PC_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an ordered queue of stored entries plus the capture state.
    int                 m_st       = M_IDLE;
    logic [ENT_W-1:0]   m_q[$];
    logic [ENT_W-1:0]   m_rd_data  = '0;
    logic               m_rd_valid = 1'b0;
    logic               m_have_last = 1'b0;
    logic [PC_W-1:0]    m_last_pc  = '0;

    task automatic model_reset();
        m_st = M_IDLE;
        m_q.delete();
        m_rd_data   = '0;
        m_rd_valid  = 1'b0;
        m_have_last = 1'b0;
    endtask

    function automatic bit is_dup(input logic [PC_W-1:0] pc);
`ifdef TRACE_DEDUP_EN
        return m_have_last && (pc == m_last_pc);
`else
        return (pc != pc);
`endif
    endfunction

    task automatic model_step();
        m_rd_valid = 1'b0;
        if (bus.clr) begin
            m_q.delete();
            m_st = M_IDLE;
            m_have_last = 1'b0;
        end else if (m_st == M_ARMED) begin
            if (!bus.cap_en) begin
                m_st = M_IDLE;
            end else if (is_dup(bus.pc_i)) begin
                m_st = M_ARMED;
            end else if (!bus.mode && m_q.size() == DEPTH) begin
                m_st = M_STOPPED;
            end else begin
                m_q.push_back({bus.pc_i, bus.instr_i});
                if (m_q.size() > DEPTH) void'(m_q.pop_front());
                m_have_last = 1'b1;
                m_last_pc   = bus.pc_i;
                if ((!bus.mode && m_q.size() == DEPTH) ||
                    (bus.bp_en && bus.pc_i == bus.bp_addr))
                    m_st = M_STOPPED;
            end
        end else begin
            if (bus.rd_req && m_q.size() > 0) begin
                m_rd_data  = m_q.pop_front();
                m_rd_valid = 1'b1;
            end
            if (m_st == M_IDLE && bus.cap_en) m_st = M_ARMED;
            else if (m_st == M_STOPPED && !bus.cap_en) m_st = M_IDLE;
        end
    endtask

    always @(negedge rstn) model_reset();

    always @(posedge clk) begin
        if (!rstn) model_reset();
        else       model_step();
    end

    bit cmp_on = 1'b0;
    always @(negedge clk) begin
        if (cmp_on) begin
            check("rd_valid", 64'(bus.rd_valid), 64'(m_rd_valid));
            check("rd_data",  64'(bus.rd_data),  64'(m_rd_data));
            check("count",    64'(bus.count),    64'(m_q.size()));
            check("full",     64'(bus.full),     64'(m_q.size() == DEPTH));
            check("stopped",  64'(bus.stopped),  64'(m_st == M_STOPPED));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        bus.cap_en  = 1'b0;
        bus.rd_req  = 1'b0;
        bus.clr     = 1'b0;
        bus.bp_en   = 1'b0;
        bus.mode    = 1'b0;
        bus.bp_addr = '0;
    endtask

    task automatic do_clr();
        idle_inputs();
        bus.clr = 1'b1;
        cyc();
        bus.clr = 1'b0;
    endtask

    task automatic drain(input logic [31:0] base, input int n, input string tag);
        logic [ENT_W-1:0] d;
        bus.rd_req = 1'b1;
        for (int i = 0; i < n; i++) begin
            cyc();
            d = bus.rd_data;
            check({tag, "_rd_valid"}, 64'(bus.rd_valid), 64'(1));
            check({tag, "_rd_pc"}, 64'(d[ENT_W-1:INSTR_W]), 64'(base + 32'(4 * i)));
        end
        bus.rd_req = 1'b0;
    endtask

    initial begin
        logic [ENT_W-1:0] d;
        int n3008;
        logic [PC_W-1:0] dpcs [9];
        idle_inputs();
        bus.pc_i    = '0;
        bus.instr_i = '0;
        cmp_on      = 1'b1;
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        check("reset_count",    64'(bus.count),    64'(0));
        check("reset_rd_valid", 64'(bus.rd_valid), 64'(0));
        check("reset_rd_data",  64'(bus.rd_data),  64'(0));
        check("reset_full",     64'(bus.full),     64'(0));
        check("reset_stopped",  64'(bus.stopped),  64'(0));

        // Stop-when-full capture
        do_clr();
        bus.cap_en = 1'b1;
        bus.pc_i   = 32'h3000;
        cyc();
        for (int i = 0; i < 20; i++) begin
            bus.pc_i    = 32'h3000 + 32'(4 * i);
            bus.instr_i = $urandom;
            cyc();
            if (i == 14) check("full_pre_stop", 64'(bus.stopped), 64'(0));
            if (i == 15) begin
                check("full_stopped", 64'(bus.stopped), 64'(1));
                check("full_count",   64'(bus.count),   64'(16));
                check("full_flag",    64'(bus.full),    64'(1));
            end
        end
        check("full_count_hold", 64'(bus.count), 64'(16));
        bus.cap_en = 1'b0;
        cyc();
        drain(32'h3000, 16, "full");
        cyc();
        check("full_drained", 64'(bus.count), 64'(0));

        // Circular capture
        do_clr();
        bus.mode   = 1'b1;
        bus.cap_en = 1'b1;
        cyc();
        for (int i = 0; i < 20; i++) begin
            bus.pc_i    = 32'h3000 + 32'(4 * i);
            bus.instr_i = $urandom;
            cyc();
        end
        check("circ_count",   64'(bus.count),   64'(16));
        check("circ_stopped", 64'(bus.stopped), 64'(0));
        bus.cap_en = 1'b0;
        cyc();
        drain(32'h3010, 16, "circ");

        // Breakpoint stop
        do_clr();
        bus.bp_en   = 1'b1;
        bus.bp_addr = 32'h300C;
        bus.cap_en  = 1'b1;
        cyc();
        for (int i = 0; i < 8; i++) begin
            bus.pc_i    = 32'h3000 + 32'(4 * i);
            bus.instr_i = $urandom;
            cyc();
            if (i == 2) check("bp_pre_stop", 64'(bus.stopped), 64'(0));
            if (i == 3) begin
                check("bp_stopped", 64'(bus.stopped), 64'(1));
                check("bp_count",   64'(bus.count),   64'(4));
            end
        end
        check("bp_count_hold", 64'(bus.count), 64'(4));
        bus.cap_en = 1'b0;
        bus.bp_en  = 1'b0;
        cyc();
        drain(32'h3000, 4, "bp");
        bus.rd_req = 1'b1;
        cyc();
        check("empty_rd_valid", 64'(bus.rd_valid), 64'(0));
        bus.rd_req = 1'b0;

        // Reads while armed are ignored; clr beats a same-edge read
        do_clr();
        bus.cap_en = 1'b1;
        cyc();
        bus.rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.pc_i = 32'h3100 + 32'(4 * i);
            cyc();
            check("armed_rd_valid", 64'(bus.rd_valid), 64'(0));
        end
        check("armed_rd_count", 64'(bus.count), 64'(3));
        bus.cap_en = 1'b0;
        bus.rd_req = 1'b0;
        cyc();
        bus.clr    = 1'b1;
        bus.rd_req = 1'b1;
        cyc();
        check("clr_rd_count", 64'(bus.count),    64'(0));
        check("clr_rd_valid", 64'(bus.rd_valid), 64'(0));
        bus.clr = 1'b0;
        cyc();
        check("clr_then_rd_valid", 64'(bus.rd_valid), 64'(0));
        bus.rd_req = 1'b0;

        // Reset in the middle of a capture
        do_clr();
        bus.cap_en = 1'b1;
        cyc();
        for (int i = 0; i < 5; i++) begin
            bus.pc_i = 32'h3200 + 32'(4 * i);
            cyc();
        end
        check("pre_rst_count", 64'(bus.count), 64'(5));
        bus.cap_en = 1'b0;
        rstn = 1'b0;
        #1;
        check("rst_count",    64'(bus.count),    64'(0));
        check("rst_stopped",  64'(bus.stopped),  64'(0));
        check("rst_rd_data",  64'(bus.rd_data),  64'(0));
        check("rst_rd_valid", 64'(bus.rd_valid), 64'(0));
        cyc();
        rstn = 1'b1;
        repeat (3) cyc();
        check("post_rst_count", 64'(bus.count), 64'(0));

        // Stalled PC
        do_clr();
        dpcs = '{32'h3000, 32'h3004, 32'h3008, 32'h3008, 32'h3008,
                 32'h3008, 32'h3008, 32'h3008, 32'h300C};
        bus.cap_en = 1'b1;
        cyc();
        for (int i = 0; i < 9; i++) begin
            bus.pc_i = dpcs[i];
            cyc();
        end
        bus.cap_en = 1'b0;
        cyc();
`ifdef TRACE_DEDUP_EN
        check("dedup_count", 64'(bus.count), 64'(4));
`else
        check("dedup_count", 64'(bus.count), 64'(9));
`endif
        n3008 = 0;
        bus.rd_req = 1'b1;
        for (int i = 0; i < 9; i++) begin
            cyc();
            d = bus.rd_data;
            if (bus.rd_valid && d[ENT_W-1:INSTR_W] == 32'h3008) n3008++;
        end
        bus.rd_req = 1'b0;
`ifdef TRACE_DEDUP_EN
        check("dedup_3008_entries", 64'(n3008), 64'(1));
`else
        check("dedup_3008_entries", 64'(n3008), 64'(6));
`endif

        // Random traffic
        do_clr();
        for (int i = 0; i < 3000; i++) begin
            rstn = ($urandom_range(0, 299) != 0);
            bus.cap_en = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 49) == 0) bus.mode = ~bus.mode;
            bus.rd_req  = $urandom_range(0, 1) == 1;
            bus.clr     = ($urandom_range(0, 63) == 0);
            bus.bp_en   = ($urandom_range(0, 3) == 0);
            bus.bp_addr = 32'h3000 + 32'(4 * $urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0)
                bus.pc_i = 32'h3000 + 32'(4 * $urandom_range(0, 15));
            bus.instr_i = $urandom;
            cyc();
        end
        rstn = 1'b1;
        idle_inputs();
        repeat (2) cyc();

        cmp_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
